// File: rtl/wb_regfile.sv
// RV32I integer register file: two decode read ports, one write-back write port,
// a debug read port and a committed-write counter. Optional: WB_REGFILE_BYPASS_EN.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              we_in,
    input  logic [ADDR_W-1:0] waddr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              re1_in,
    input  logic [ADDR_W-1:0] raddr1_in,
    output logic [DATA_W-1:0] rdata1_out,
    input  logic              re2_in,
    input  logic [ADDR_W-1:0] raddr2_in,
    output logic [DATA_W-1:0] rdata2_out,
    input  logic [ADDR_W-1:0] dbg_addr_in,
    output logic [DATA_W-1:0] dbg_data_out,
    output logic [CNT_W-1:0]  wr_count_out
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [1:NREG-1];
    logic [DATA_W-1:0] regs_d [1:NREG-1];
    logic [CNT_W-1:0]  wr_count_q;
    logic [CNT_W-1:0]  wr_count_d;
    logic              commit;

    // x0 is never stored, so a write to it is simply not a commit
    assign commit = rdy_in && we_in && (waddr_in != '0);

    function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 1; i < NREG; i++) begin
            if (a == ADDR_W'(i)) v = regs_q[i];
        end
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] rd_port(
        input logic              re,
        input logic [ADDR_W-1:0] a
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (rst_in && re && (a != '0)) begin
`ifdef WB_REGFILE_BYPASS_EN
            if (commit && (a == waddr_in)) v = wdata_in;
            else v = stored(a);
`else
            v = stored(a);
`endif
        end
        return v;
    endfunction

    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (commit) begin
            for (int i = 1; i < NREG; i++) begin
                if (waddr_in == ADDR_W'(i)) regs_d[i] = wdata_in;
            end
            wr_count_d = wr_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        rdata1_out   = rd_port(re1_in, raddr1_in);
        rdata2_out   = rd_port(re2_in, raddr2_in);
        dbg_data_out = rst_in ? stored(dbg_addr_in) : '0;
    end

    assign wr_count_out = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed steps plus random traffic
// against an array-based reference model.
module tb_wb_regfile;
    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        we_in;
    logic [4:0]  waddr_in;
    logic [31:0] wdata_in;
    logic        re1_in;
    logic [4:0]  raddr1_in;
    logic [31:0] rdata1_out;
    logic        re2_in;
    logic [4:0]  raddr2_in;
    logic [31:0] rdata2_out;
    logic [4:0]  dbg_addr_in;
    logic [31:0] dbg_data_out;
    logic [31:0] wr_count_out;

    logic [31:0] mdl [32];
    logic [31:0] mcnt;
    int npass;
    int ntotal;
    logic byp;

    wb_regfile dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .we_in       (we_in),
        .waddr_in    (waddr_in),
        .wdata_in    (wdata_in),
        .re1_in      (re1_in),
        .raddr1_in   (raddr1_in),
        .rdata1_out  (rdata1_out),
        .re2_in      (re2_in),
        .raddr2_in   (raddr2_in),
        .rdata2_out  (rdata2_out),
        .dbg_addr_in (dbg_addr_in),
        .dbg_data_out(dbg_data_out),
        .wr_count_out(wr_count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic re,
                                           input logic [4:0] a);
        if (!rst_in || !re || a == 5'd0) return 32'h0;
        if (byp && rdy_in && we_in && a == waddr_in) return wdata_in;
        return mdl[a];
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] d;
        d = (!rst_in || dbg_addr_in == 5'd0) ? 32'h0 : mdl[dbg_addr_in];
        chk({tag, "_rd1"}, rdata1_out, exp_rd(re1_in, raddr1_in));
        chk({tag, "_rd2"}, rdata2_out, exp_rd(re2_in, raddr2_in));
        chk({tag, "_dbg"}, dbg_data_out, d);
        chk({tag, "_cnt"}, wr_count_out, mcnt);
    endtask

    task automatic drive(input logic rdy, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic r1,
                         input logic [4:0] a1, input logic r2,
                         input logic [4:0] a2, input logic [4:0] da);
        rdy_in = rdy; we_in = we; waddr_in = wa; wdata_in = wd;
        re1_in = r1; raddr1_in = a1; re2_in = r2; raddr2_in = a2;
        dbg_addr_in = da;
    endtask

    task automatic tick();
        @(posedge clk_in);
        if (rst_in && rdy_in && we_in && waddr_in != 5'd0) begin
            mdl[waddr_in] = wdata_in;
            mcnt = mcnt + 32'd1;
        end
        #1;
    endtask

    initial begin
        npass = 0;
        ntotal = 0;
`ifdef WB_REGFILE_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mcnt = 32'h0;
        rst_in = 1'b0;
        drive(1, 1, 5'd9, 32'hAAAA5555, 1, 5'd9, 1, 5'd9, 5'd9);
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_hold_rd1", rdata1_out, 32'h0);
        chk("rst_hold_dbg", dbg_data_out, 32'h0);
        chk("rst_hold_cnt", wr_count_out, 32'h0);
        drive(1, 0, 5'd0, 32'h0, 1, 5'd0, 1, 5'd0, 5'd0);
        rst_in = 1'b1;
        for (int i = 0; i < 32; i++) begin
            raddr1_in = 5'(i);
            raddr2_in = 5'(31 - i);
            #1;
            chk($sformatf("rst_rd1_x%0d", i), rdata1_out, 32'h0);
            chk($sformatf("rst_rd2_x%0d", 31 - i), rdata2_out, 32'h0);
        end
        chk("rst_cnt", wr_count_out, 32'h0);

        // basic write then read
        drive(1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 5'd0, 5'd0);
        tick();
        drive(1, 0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd5, 5'd5);
        #1;
        chk("basic_rd1", rdata1_out, 32'hDEADBEEF);
        chk("basic_cnt", wr_count_out, 32'd1);
        check_all("basic");

        // x0 protection
        drive(1, 1, 5'd0, 32'h12345678, 1, 5'd0, 1, 5'd0, 5'd0);
        tick();
        chk("x0_rd1", rdata1_out, 32'h0);
        chk("x0_dbg", dbg_data_out, 32'h0);
        chk("x0_cnt", wr_count_out, 32'd1);

        // read enable low
        drive(1, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd5, 5'd5);
        #1;
        chk("re2_off", rdata2_out, 32'h0);
        chk("re1_on", rdata1_out, 32'hDEADBEEF);

        // same-cycle read/write
        drive(1, 1, 5'd7, 32'h11, 0, 5'd0, 0, 5'd0, 5'd0);
        tick();
        drive(1, 1, 5'd7, 32'h22, 1, 5'd7, 1, 5'd7, 5'd7);
        #1;
        chk("rw_rd1", rdata1_out, byp ? 32'h22 : 32'h11);
        chk("rw_dbg", dbg_data_out, 32'h11);
        check_all("rw");
        tick();
        drive(1, 0, 5'd0, 32'h0, 1, 5'd7, 0, 5'd0, 5'd7);
        #1;
        chk("rw_next_rd1", rdata1_out, 32'h22);
        chk("rw_cnt", wr_count_out, 32'd3);

        // rdy_in gating
        drive(0, 1, 5'd3, 32'h55, 1, 5'd3, 1, 5'd3, 5'd3);
        #1;
        chk("rdy0_rd1", rdata1_out, 32'h0);
        tick();
        chk("rdy0_x3", rdata1_out, 32'h0);
        chk("rdy0_cnt", wr_count_out, 32'd3);
        drive(1, 1, 5'd3, 32'h55, 1, 5'd3, 1, 5'd3, 5'd3);
        tick();
        drive(1, 0, 5'd0, 32'h0, 1, 5'd3, 1, 5'd3, 5'd3);
        #1;
        chk("rdy1_x3", rdata2_out, 32'h55);
        chk("rdy1_cnt", wr_count_out, 32'd4);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 4) != 0, $urandom % 2, 5'($urandom),
                  $urandom, ($urandom % 8) != 0, 5'($urandom),
                  ($urandom % 8) != 0, 5'($urandom), 5'($urandom));
            if (($urandom % 4) == 0) raddr1_in = waddr_in;
            #1;
            check_all($sformatf("rnd%0d", n));
            tick();
        end

        // counter wrap
        drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 5'd0);
        force dut.wr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count_q;
        mcnt = 32'hFFFF_FFFF;
        chk("wrap_pre", wr_count_out, 32'hFFFF_FFFF);
        drive(1, 1, 5'd3, 32'h55, 0, 5'd0, 0, 5'd0, 5'd0);
        tick();
        chk("wrap_post", wr_count_out, 32'h0);

        // asynchronous reset mid-cycle
        drive(1, 1, 5'd3, 32'h99, 1, 5'd3, 1, 5'd3, 5'd3);
        #1;
        chk("prerst_dbg", dbg_data_out, 32'h55);
        #1;
        rst_in = 1'b0;
        #1;
        chk("arst_rd1", rdata1_out, 32'h0);
        chk("arst_rd2", rdata2_out, 32'h0);
        chk("arst_dbg", dbg_data_out, 32'h0);
        chk("arst_cnt", wr_count_out, 32'h0);
        tick();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mcnt = 32'h0;
        rst_in = 1'b1;
        drive(1, 0, 5'd0, 32'h0, 1, 5'd3, 1, 5'd3, 5'd3);
        #1;
        chk("arst_x3", rdata1_out, 32'h0);
        check_all("post_rst");

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural integer register file for the RV32I pipeline: 32 x 32-bit registers, x0 hardwired to zero.
- It is the responder to the decode stage's two register-read requests (enable plus 5-bit address per port). Both reads are answered combinationally in the same cycle.
- It accepts one synchronous write per cycle from the write-back stage.
- It also provides a debug read port and a committed-write counter for simulation and trace checks.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; the file holds 2**ADDR_W entries.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk_in  input  1  system clock; all writes occur on its rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready. When low, writes and counter updates are frozen; reads still operate.
- we_in  input  1  write enable from write-back.
- waddr_in  input  ADDR_W  write destination register.
- wdata_in  input  DATA_W  write data.
- re1_in  input  1  read enable, port 1 (decode rs1 request).
- raddr1_in  input  ADDR_W  read address, port 1.
- rdata1_out  output  DATA_W  read data, port 1.
- re2_in  input  1  read enable, port 2 (decode rs2 request).
- raddr2_in  input  ADDR_W  read address, port 2.
- rdata2_out  output  DATA_W  read data, port 2.
- dbg_addr_in  input  ADDR_W  debug read address.
- dbg_data_out  output  DATA_W  debug read data (combinational, never bypassed).
- wr_count_out  output  CNT_W  number of committed writes since reset.

Behaviour:
- Storage: entries 1..31 are flops. Entry 0 is not stored; a read of x0 always returns 0.
- Reset (rst_in low):
  - Asynchronously clears entries 1..31 and wr_count_out to 0.
  - While rst_in is low: rdata1_out = rdata2_out = dbg_data_out = 0, and writes are ignored.
  - Reset asserted mid-operation discards any write on that edge.
- Write commit: on a rising edge of clk_in, a write commits only when all of the following hold:
  - rst_in is high;
  - rdy_in is 1;
  - we_in is 1;
  - waddr_in != 0.
  On commit, regs[waddr_in] <= wdata_in and wr_count_out <= wr_count_out + 1.
- wr_count_out wraps from 2**CNT_W-1 to 0 with no flag.
- A write with waddr_in == 0 is dropped and does not increment the counter.
- Read, per port n, combinational with zero latency:
  - re_n low -> 0.
  - raddr_n == 0 -> 0.
  - Otherwise, see bypass under Optional Feature.
  - Otherwise -> regs[raddr_n].
- Ports 1 and 2 may read the same address simultaneously and return identical values.
- rdy_in low:
  - A pending we_in is not committed and is not queued. The producer must hold it until rdy_in returns high.
  - Reads are unaffected.
- Write latency: data written at edge k is visible from the stored array in cycle k+1.
- No handshake on reads; consumers sample the read data in the same cycle they drive the request.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined:
  - A read port returns wdata_in in the same cycle when re_n=1, raddr_n=waddr_in!=0, we_in=1, rdy_in=1 and rst_in=1.
  - This removes the one-cycle write-to-read hazard, so decode needs no extra forwarding for the write-back stage.
  - The debug port is still not bypassed.
- Not defined: reads always return the stored value, so a same-cycle write is visible only from the next cycle.

Test Plan:
- Reset: hold rst_in=0 for 3 cycles, then read all 32 addresses on both ports -> all 0, wr_count_out=0.
- Basic write/read: write x5=0xDEADBEEF, then next cycle re1=1, raddr1=5 -> rdata1_out=0xDEADBEEF and wr_count_out=1.
- x0 protection: write x0=0x12345678 -> reads of x0 return 0 and wr_count_out is unchanged.
- Read enable: with re2=0 and raddr2=5 -> rdata2_out=0.
- Same-cycle read/write: x7 holds 0x11; in one cycle write x7=0x22 while reading x7 on port 1.
  - Without the macro: port 1 returns 0x11 that cycle and 0x22 the next.
  - With the macro: port 1 returns 0x22 immediately.
  - The debug port returns 0x11 that cycle in both builds.
- rdy_in and reset: with rdy_in=0, write x3=0x55 -> x3 stays 0 and the counter is unchanged.
  - Then with rdy_in=1, write x3=0x55 -> x3 = 0x55.
  - Then assert rst_in=0 mid-cycle -> rdata outputs go to 0 immediately, without waiting for a clock edge.
- Counter wrap: force the counter to 0xFFFFFFFF (CNT_W=32), then commit one write -> wr_count_out = 0.
